// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_e;

    typedef enum logic [2:0] {
        ZERO,
        PM1,
        PM2,
        NM1,
        NM2
    } booth_digit_e;

    // Each RUN cycle retires two multiplier bits.
    function automatic int iter_count(input int width);
        return width / 2;
    endfunction

    function automatic int counter_width(input int width);
        return $clog2(width / 2 + 1);
    endfunction

    localparam int MUL_ITERS = iter_count(MUL_WIDTH);
    localparam int MUL_CNT_W = counter_width(MUL_WIDTH);

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: 3-bit window {b[i+1], b[i], b[i-1]} to digit select flags.
module booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0] window_i,
    output logic       neg_o,
    output logic       dbl_o,
    output logic       zero_o
);

    booth_digit_e digit;

    always_comb begin
        case (window_i)
            3'b001, 3'b010: digit = PM1;
            3'b011:         digit = PM2;
            3'b100:         digit = NM2;
            3'b101, 3'b110: digit = NM1;
            default:        digit = ZERO;
        endcase
        neg_o  = (digit == NM1) || (digit == NM2);
        dbl_o  = (digit == PM2) || (digit == NM2);
        zero_o = (digit == ZERO);
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTHxWIDTH radix-4 Booth multiplier with start/done handshake; Z = {HI, LO}.
// Optional early termination on an exhausted multiplier: define BOOTH_EARLY_TERM_EN.
module booth_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z
);

    localparam int ITERS = iter_count(WIDTH);
    localparam int CNT_W = counter_width(WIDTH);
    localparam int PW    = WIDTH + 2;          // P_hi width, absorbs 2*(-2^(WIDTH-1))
    localparam int AW    = PW + WIDTH + 1;     // {P_hi, P_lo, q_-1}

    mul_state_e         state_q, state_d;
    logic [PW-1:0]      m_q, m_d;
    logic [PW-1:0]      p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic               enc_neg, enc_dbl, enc_zero;
    logic [PW-1:0]      mag, addend, sum;
    logic [AW-1:0]      acc_step;

    booth_r4_enc u_enc (
        .window_i ({p_lo_q[1:0], qm1_q}),
        .neg_o    (enc_neg),
        .dbl_o    (enc_dbl),
        .zero_o   (enc_zero)
    );

    always_comb begin
        mag      = enc_dbl ? {m_q[PW-2:0], 1'b0} : m_q;
        addend   = enc_zero ? '0 : (enc_neg ? (~mag + PW'(1)) : mag);
        sum      = p_hi_q + addend;
        acc_step = {{2{sum[PW-1]}}, sum, p_lo_q[WIDTH-1:1]};
    end

`ifdef BOOTH_EARLY_TERM_EN
    localparam int SH_W = $clog2(WIDTH + 1);

    logic            et_hit;
    logic [SH_W-1:0] rem;
    logic [AW-1:0]   acc_et;

    // Unconsumed multiplier bits sit in P_lo[WIDTH-1-2*cnt:0]; if they all match
    // q_-1 every remaining digit is zero and only the final sign-extension remains.
    always_comb begin
        et_hit = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < WIDTH - 2 * int'(cnt_q)) && (p_lo_q[i] != qm1_q)) begin
                et_hit = 1'b0;
            end
        end
        rem    = SH_W'(WIDTH - 2 * int'(cnt_q));
        acc_et = AW'($signed({p_hi_q, p_lo_q, qm1_q}) >>> rem);
    end
`endif

    // NOTE: every output of this block is given a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        z_d     = z_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = {{2{A[WIDTH-1]}}, A};
                    p_hi_d  = '0;
                    p_lo_d  = B;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
                if (et_hit) begin
                    {p_hi_d, p_lo_d, qm1_d} = acc_et;
                    state_d                 = DONE;
                end else begin
                    {p_hi_d, p_lo_d, qm1_d} = acc_step;
                    cnt_d                   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d = DONE;
                    end
                end
`else
                {p_hi_d, p_lo_d, qm1_d} = acc_step;
                cnt_d                   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Z only changes on entry to DONE and holds through IDLE.
        if ((state_q == RUN) && (state_d == DONE)) begin
            z_d = {p_hi_d[WIDTH-1:0], p_lo_d};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Z    = z_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed scoreboard bench for booth_multiplier; expected latency follows BOOTH_EARLY_TERM_EN.
module tb_booth_multiplier;
    import mul_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] Z;

    int             checks   = 0;
    int             failures = 0;
    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];
    logic [2*W-1:0] last_z;
    int             done_cnt;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Edges from the accepting edge up to and including the one entering DONE.
    function automatic int exp_latency(input logic [31:0] b);
        int   lat;
`ifdef BOOTH_EARLY_TERM_EN
        logic q;
        bit   all_eq;
        lat = 0;
        for (int k = 0; k < MUL_ITERS && lat == 0; k++) begin
            q      = (k == 0) ? 1'b0 : b[2*k-1];
            all_eq = 1'b1;
            for (int i = 2 * k; i < 32; i++) begin
                if (b[i] !== q) all_eq = 1'b0;
            end
            if (all_eq) lat = k + 2;
        end
        if (lat == 0) lat = MUL_ITERS + 1;
`else
        lat = MUL_ITERS + 1;
`endif
        return lat;
    endfunction

    // Call at a negedge; returns just after the accepting edge with start low.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(model_product(a, b));
        lat_q.push_back(exp_latency(b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle (or after the cycle budget).
    task automatic wait_done(input string tag, input bit poke);
        int             edges;
        int             busy_cycles;
        int             exp_lat;
        bit             seen;
        logic [2*W-1:0] exp_z;
        edges       = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (poke && (i == 1 || i == 2)) begin
                    start = 1'b1;
                    A     = 32'h0000_DEAD;
                    B     = 32'hFFFF_0001;
                end else if (poke && i == 3) begin
                    start = 1'b0;
                end
                @(posedge clk);
                edges++;
            end
        end
        exp_z   = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        last_z  = exp_z;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
        check({tag, " Z"}, Z, exp_z);
        check({tag, " busy_with_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset Z", Z, 64'd0);
        clr = 1'b0;

        // 7 * -3
        launch(32'd7, 32'hFFFF_FFFD);
        wait_done("7x-3", 1'b0);
        check("7x-3 literal", Z, 64'hFFFF_FFFF_FFFF_FFEB);

        // Z holds through IDLE
        repeat (3) @(negedge clk);
        check("hold Z", Z, last_z);
        check("hold done", 64'(done), 64'd0);

        launch(32'h8000_0000, 32'h8000_0000);
        wait_done("min*min", 1'b0);
        check("min*min literal", Z, 64'h4000_0000_0000_0000);

        @(negedge clk);
        launch(32'h8000_0000, 32'd1);
        wait_done("min*1", 1'b0);
        check("min*1 literal", Z, 64'hFFFF_FFFF_8000_0000);

        // -1 * -1 followed back-to-back by 12345 * 0
        @(negedge clk);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("-1x-1", 1'b0);
        check("-1x-1 literal", Z, 64'd1);
        launch(32'd12345, 32'd0);
        wait_done("b2b 12345x0", 1'b0);
        check("b2b literal", Z, 64'd0);

        // start during RUN is ignored and not queued
        @(negedge clk);
        launch(32'd100, 32'd200);
        wait_done("100x200 poked", 1'b1);
        check("100x200 literal", Z, 64'd20000);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("no queued op", 64'(done_cnt), 64'd0);

        // clr in RUN cycle 8 discards the operation
        @(negedge clk);
        launch(32'd1234, 32'h7FFF_FFFF);
        repeat (8) @(negedge clk);
        check("mid-run busy", 64'(busy), 64'd1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(negedge clk);
        check("clr busy", 64'(busy), 64'd0);
        check("clr done", 64'(done), 64'd0);
        check("clr Z", Z, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("clr no done", 64'(done_cnt), 64'd0);

        // early-termination cases (fixed latency when the feature is off)
        launch(32'd3, 32'd5);
        wait_done("3x5", 1'b0);
        check("3x5 literal", Z, 64'd15);
        @(negedge clk);
        launch(32'd3, 32'h7FFF_FFFF);
        wait_done("3xmax", 1'b0);

        // random operands
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            launch($urandom, (n % 2 == 0) ? $urandom : $urandom_range(0, 4095));
            wait_done($sformatf("rand%0d", n), 1'b0);
        end

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
